add_sum_stage: RTL and testbench

ADD_SUM_STAGE -- requirements
Module: add_sum_stage

---
 rtl/add_sum_stage.sv | 124 ++++++++++++
 tb/tb_add_sum_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sum_stage.sv
// add_sum_stage: final sum stage of a 32-bit parallel-prefix adder.
// Derives per-bit carries from the last prefix level and the carry-in, forms
// the sum, and holds the results in a 2-entry output buffer with
// valid/ready handshakes on both sides.
// Optional feature macro: ADD_SUM_FLAGS_EN adds the flags_out port
// ({ovf, neg, zero}), which is buffered alongside each sum.
//
// state | meaning
// EMPTY | no result held; out_valid=0, in_ready=1
// ONE   | head entry holds a result; out_valid=1, in_ready=1
// FULL  | head and skid entries hold results; out_valid=1, in_ready=0
module add_sum_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] gp_in,
  input  logic [31:0] prop_in,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum_out,
  output logic        cout_out
`ifdef ADD_SUM_FLAGS_EN
  ,
  output logic [2:0]  flags_out
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

`ifdef ADD_SUM_FLAGS_EN
  localparam int ENTRY_W = 36;
`else
  localparam int ENTRY_W = 33;
`endif

  state_t             state;
  logic [32:0]        carry;
  logic [31:0]        sum_comb;
  logic [ENTRY_W-1:0] new_entry;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] skid;
  logic               push;
  logic               pop;

  // Carry into bit i: group generate of bits below, or group propagate
  // of bits below passing the carry-in through. No carry state is kept.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i <= 32; i++) begin
      carry[i] = gp_in[2*i-1] | (gp_in[2*i-2] & cin);
    end
  end

  assign sum_comb = prop_in ^ carry[31:0];

`ifdef ADD_SUM_FLAGS_EN
  logic flag_ovf;
  logic flag_neg;
  logic flag_zero;

  assign flag_ovf  = carry[31] ^ carry[32];
  assign flag_neg  = sum_comb[31];
  assign flag_zero = (sum_comb == 32'd0);
  assign new_entry = {flag_ovf, flag_neg, flag_zero, carry[32], sum_comb};
  assign flags_out = head[35:33];
`else
  assign new_entry = {carry[32], sum_comb};
`endif

  assign sum_out  = head[31:0];
  assign cout_out = head[32];

  // Handshake flags come from the state register only; reset gating keeps
  // in_ready low while rst_n is held and high on the first edge after it.
  assign in_ready  = rst_n && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy FSM and buffer entries; head always drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= new_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head  <= new_entry;
          end else if (push) begin
            skid  <= new_entry;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sum_stage.sv
// Self-checking bench for add_sum_stage: directed vectors, back-to-back
// stall, random traffic against a queue model, and reset while full.
module tb_add_sum_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] gp_in;
  logic [31:0] prop_in;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_out;
  logic        cout_out;
`ifdef ADD_SUM_FLAGS_EN
  logic [2:0]  flags_out;
`endif

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic [2:0]  flags;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;

  add_sum_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gp_in     (gp_in),
    .prop_in   (prop_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out)
`ifdef ADD_SUM_FLAGS_EN
    ,
    .flags_out (flags_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference prefix: G(i:0) is the carry out of the low i+1 bits with no
  // carry-in, P(i:0) is whether every low bit propagates.
  function automatic logic [63:0] ref_gp(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [63:0] mask;
    logic [63:0] s;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      mask = (64'd1 << (i + 1)) - 64'd1;
      s = ({32'd0, a} & mask) + ({32'd0, b} & mask);
      r[2*i+1] = s[i+1];
      r[2*i]   = ((({32'd0, a} ^ {32'd0, b}) & mask) == mask);
    end
    return r;
  endfunction

  task automatic set_beat(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] full;
    full     = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    gp_in    = ref_gp(a, b);
    prop_in  = a ^ b;
    cin      = ci;
    in_valid = 1'b1;
    cur_exp.sum   = full[31:0];
    cur_exp.cout  = full[32];
    cur_exp.flags = {(a[31] == b[31]) && (full[31] != a[31]), full[31], full[31:0] == 32'd0};
  endtask

  task automatic set_idle();
    in_valid = 1'b0;
    gp_in    = {$urandom, $urandom};
    prop_in  = $urandom;
    cin      = 1'($urandom_range(0, 1));
  endtask

  // One clock: model transfers decided from model occupancy, then outputs
  // compared against the model on the falling edge.
  task automatic cycle(input string name);
    bit push;
    bit pop;
    push = in_valid && (q.size() < 2);
    pop  = out_ready && (q.size() != 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(cur_exp);
    @(negedge clk);
    n_tests++;
    if (out_valid !== (q.size() != 0)) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b want %b", name, out_valid, q.size() != 0);
    end
    n_tests++;
    if (in_ready !== (q.size() < 2)) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b want %b", name, in_ready, q.size() < 2);
    end
    if (q.size() != 0) begin
      n_tests++;
      if (sum_out !== q[0].sum || cout_out !== q[0].cout) begin
        n_fail++;
        $display("FAIL %s head: got sum=%h cout=%b want sum=%h cout=%b",
                 name, sum_out, cout_out, q[0].sum, q[0].cout);
      end
`ifdef ADD_SUM_FLAGS_EN
      n_tests++;
      if (flags_out !== q[0].flags) begin
        n_fail++;
        $display("FAIL %s flags: got %b want %b", name, flags_out, q[0].flags);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    out_ready = 1'b0;
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: got valid=%b ready=%b want 0 0", out_valid, in_ready);
    end
    n_tests++;
    if (sum_out !== 32'd0 || cout_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got sum=%h cout=%b want 0 0", sum_out, cout_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    q.delete();
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    set_beat(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    cycle("vec_wrap");
    n_tests++;
    if (out_valid !== 1'b1 || sum_out !== 32'h0 || cout_out !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_wrap_const: got v=%b sum=%h cout=%b want 1 00000000 1", out_valid, sum_out, cout_out);
    end
`ifdef ADD_SUM_FLAGS_EN
    n_tests++;
    if (flags_out !== 3'b001) begin
      n_fail++;
      $display("FAIL vec_wrap_flags: got %b want 001", flags_out);
    end
`endif
    set_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    cycle("vec_ovf");
    n_tests++;
    if (sum_out !== 32'h8000_0000 || cout_out !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_ovf_const: got sum=%h cout=%b want 80000000 0", sum_out, cout_out);
    end
`ifdef ADD_SUM_FLAGS_EN
    n_tests++;
    if (flags_out !== 3'b110) begin
      n_fail++;
      $display("FAIL vec_ovf_flags: got %b want 110", flags_out);
    end
`endif
    set_beat(32'h0, 32'h0, 1'b1);
    cycle("vec_cin");
    n_tests++;
    if (sum_out !== 32'h1 || cout_out !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_cin_const: got sum=%h cout=%b want 00000001 0", sum_out, cout_out);
    end
    set_beat(32'hFFFF_FFFF, 32'h0, 1'b1);
    cycle("vec_cin_ripple");
    set_idle();
    cycle("vec_drain");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_beat(32'h0, 32'h1, 1'b0);
    cycle("b2b_push1");
    set_beat(32'h0, 32'h2, 1'b0);
    cycle("b2b_push2");
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full_ready: got %b want 0", in_ready);
    end
    set_beat(32'h0, 32'h3, 1'b0);
    cycle("b2b_hold3");
    cycle("b2b_hold3b");
    n_tests++;
    if (sum_out !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_stall_head: got %h want 00000001", sum_out);
    end
    out_ready = 1'b1;
    cycle("b2b_pop1");
    n_tests++;
    if (in_ready !== 1'b1 || sum_out !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_after_pop1: got ready=%b sum=%h want 1 00000002", in_ready, sum_out);
    end
    cycle("b2b_push3_pop2");
    set_idle();
    n_tests++;
    if (sum_out !== 32'd3) begin
      n_fail++;
      $display("FAIL b2b_third: got %h want 00000003", sum_out);
    end
    cycle("b2b_pop3");
    cycle("b2b_empty");
  endtask

  task automatic test_random();
    int accepted;
    int cycles;
    logic [31:0] a;
    logic [31:0] b;
    accepted = 0;
    cycles = 0;
    while (accepted < 10000 && cycles < 40000) begin
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 7))
          0: a = 32'hFFFF_FFFF;
          1: a = 32'h7FFF_FFFF;
          2: a = 32'h0;
          default: a = $urandom;
        endcase
        b = ($urandom_range(0, 7) == 0) ? (~a) : $urandom;
        set_beat(a, b, 1'($urandom_range(0, 1)));
      end else begin
        set_idle();
      end
      if (in_valid && q.size() < 2) accepted++;
      cycle("rand");
      cycles++;
    end
    n_tests++;
    if (accepted < 10000) begin
      n_fail++;
      $display("FAIL rand_budget: got %0d beats want 10000", accepted);
    end
    set_idle();
    out_ready = 1'b1;
    repeat (3) cycle("rand_drain");
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    set_beat(32'h1234_5678, 32'h1111_1111, 1'b0);
    cycle("rst_fill1");
    set_beat(32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
    cycle("rst_fill2");
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum_out !== 32'd0 || cout_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full_async: got v=%b r=%b sum=%h cout=%b want 0 0 0 0",
               out_valid, in_ready, sum_out, cout_out);
    end
    q.delete();
    set_beat($urandom, $urandom, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full_hold: got v=%b r=%b want 0 0", out_valid, in_ready);
    end
    set_idle();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_full_release: got ready=%b want 1", in_ready);
    end
    repeat (3) cycle("rst_no_stale");
    set_beat(32'h0000_00FF, 32'h0000_0001, 1'b0);
    cycle("rst_recover");
    set_idle();
    cycle("rst_recover_drain");
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
